aes_block_loader: RTL and testbench
===================================

Name: aes_block_loader

Overview:
- Upstream stage of the AES SPI master pair; supplies its plaintext/ciphertext block and key.
- Accepts a byte stream with valid/ready handshake: a command byte, then key or message bytes, MSB first.
- Assembles bytes into staging registers and commits them atomically to the master's block and key inputs.
- Issues a one-cycle start, waits for core completion, holds the 128-bit result until acknowledged.

Parameters:
- nk, 4, key length in 32-bit words (4/6/8); key byte count = 4*nk
- nb, 4, block length in 32-bit words; block byte count = 4*nb (fixed 16 in this design)
- TIMEOUT_CYCLES, 1024, inter-byte timeout limit (used only with the optional feature)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- byte_in  in  8  stream data
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  loader can accept a byte
- msg_out  out  32*nb  committed block to master from_Real_msg
- key_out  out  32*nk  committed key to master from_Real_key
- start  out  1  one-cycle pulse to launch master transfer
- core_done  in  1  master/core finished; core_result valid this cycle
- core_result  in  32*nb  returned block (master Sipo_Register)
- result  out  32*nb  latched result
- result_valid  out  1  result held, awaiting ack
- result_ack  in  1  consumer takes result
- key_loaded  out  1  a complete key has been committed
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (async): state IDLE; msg_out, key_out, result and staging all zero; start, result_valid, key_loaded, err at 0; byte counter at 0.
- Transfer: a byte is accepted on a rising edge with byte_valid & byte_ready. byte_ready = 1 in IDLE, LOAD_KEY and LOAD_MSG; 0 in all other states.
- IDLE: the accepted byte is a command.
  - 0x4B ('K') -> LOAD_KEY, counter := 0.
  - 0x4D ('M') with key_loaded=1 -> LOAD_MSG, counter := 0.
  - 0x4D with key_loaded=0, or any other value -> err pulse next cycle; stay IDLE; byte dropped.
- Loading:
  - Bytes shift into the staging register MSB first: the first byte lands in bits [W-1:W-8].
  - The counter increments per accepted byte.
- LOAD_KEY: on the 4*nk-th byte, commit staging to key_out and set key_loaded=1 the same edge; -> IDLE. msg_out is unchanged.
- LOAD_MSG: on the 16th byte, commit staging to msg_out; -> START.
  - Committed outputs never show partial data.
- START: start=1 for exactly one cycle, 1 cycle after the last message byte is accepted; -> WAIT_DONE.
- WAIT_DONE: on core_done=1, latch core_result into result and set result_valid=1 the same edge; -> HOLD.
- core_done is ignored in every state except WAIT_DONE.
- HOLD: result_valid stays 1. On result_ack=1, clear result_valid; -> IDLE. result keeps its value.
- Back-to-back: a new 'M' is accepted only after returning to IDLE. The previous key is reused.
- Reset mid-load or mid-wait: all outputs and staging return to reset values immediately. key_loaded=0, so a key must be reloaded.

Optional Feature:
- Macro AES_LOADER_TIMEOUT_EN.
- Defined:
  - In LOAD_KEY/LOAD_MSG a counter counts cycles since the last accepted byte.
  - When the count reaches TIMEOUT_CYCLES with no byte, pulse err, discard staging and go to IDLE.
  - Committed msg_out/key_out/key_loaded are untouched.
- Undefined: no counter is present; a partial load waits indefinitely.

Test Plan:
- Key load: send 0x4B then bytes 00,01,...,0F -> key_out=000102030405060708090a0b0c0d0e0f and key_loaded=1 on the edge accepting 0x0F; msg_out stays 0.
- Message and launch: after key load, send 0x4D then 00,11,22,...,ff -> msg_out=00112233445566778899aabbccddeeff; start high for exactly one cycle, 1 cycle after 0xff is accepted; busy=1.
- Result handshake: in WAIT_DONE, pulse core_done with core_result=69c4e0d86a7b0430d8cdb78070b4c55a -> result equals it and result_valid=1; hold result_ack=0 for 5 cycles then 1 -> result_valid=0 and byte_ready=1 next cycle.
- Errors:
  - Send 0x4D right after reset -> err pulse, state IDLE, no start.
  - Send 0x55 -> err pulse.
  - core_done pulsed in IDLE -> result unchanged.
- Reset mid-operation: assert rst after 7 message bytes -> msg_out=0, key_out=0, key_loaded=0, busy=0 asynchronously, with no start.
- Timeout (AES_LOADER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): send 0x4D plus 3 bytes, then stall 16 cycles -> err pulse, IDLE, msg_out unchanged; without the macro, the loader is still in LOAD_MSG after 100 idle cycles.

Source files
------------

// File: rtl/aes_block_loader.sv
// Byte-stream loader feeding the AES SPI master: assembles key/message bytes,
// commits them atomically, launches the core and holds its result until acked.
// Optional inter-byte timeout enabled by defining AES_LOADER_TIMEOUT_EN.
module aes_block_loader #(
  parameter int nk             = 4,
  parameter int nb             = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [32*nb-1:0] msg_out,
  output logic [32*nk-1:0] key_out,
  output logic             start,
  input  logic             core_done,
  input  logic [32*nb-1:0] core_result,
  output logic [32*nb-1:0] result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             key_loaded,
  output logic             busy,
  output logic             err,
  output logic [2:0]       fsm_state
);

  localparam int KW        = 32 * nk;
  localparam int MW        = 32 * nb;
  localparam int KEY_BYTES = 4 * nk;
  localparam int MSG_BYTES = 4 * nb;
  localparam int CW        = 6;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_KEY  = 3'd1,
    LOAD_MSG  = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4,
    HOLD      = 3'd5
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic [KW-1:0] key_stage;
  logic [MW-1:0] msg_stage;
  logic [KW-1:0] key_shift;
  logic [MW-1:0] msg_shift;

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
  // byte_ready depends only on state, never on byte_valid.
  logic accept;
  logic cmd_err, clr_load, key_commit, msg_commit, latch_result, timeout_hit;

  assign byte_ready = (state == IDLE) || (state == LOAD_KEY) || (state == LOAD_MSG);
  assign accept     = byte_valid && byte_ready;
  assign busy       = (state != IDLE);
  assign start      = (state == START);
  assign fsm_state  = state;

  // First byte of a load ends up in the top byte once all bytes are in.
  assign key_shift = {key_stage[KW-9:0], byte_in};
  assign msg_shift = {msg_stage[MW-9:0], byte_in};

`ifdef AES_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          loading;

  assign loading     = (state == LOAD_KEY) || (state == LOAD_MSG);
  assign timeout_hit = loading && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (loading && !accept && !timeout_hit) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    cmd_err      = 1'b0;
    clr_load     = 1'b0;
    key_commit   = 1'b0;
    msg_commit   = 1'b0;
    latch_result = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (byte_in == 8'h4B) begin
            next_state = LOAD_KEY;
            clr_load   = 1'b1;
          end else if (byte_in == 8'h4D && key_loaded) begin
            next_state = LOAD_MSG;
            clr_load   = 1'b1;
          end else begin
            cmd_err = 1'b1;
          end
        end
      end
      LOAD_KEY: begin
        if (accept && cnt == CW'(KEY_BYTES - 1)) begin
          key_commit = 1'b1;
          next_state = IDLE;
        end else if (timeout_hit) begin
          clr_load   = 1'b1;
          next_state = IDLE;
        end
      end
      LOAD_MSG: begin
        if (accept && cnt == CW'(MSG_BYTES - 1)) begin
          msg_commit = 1'b1;
          next_state = START;
        end else if (timeout_hit) begin
          clr_load   = 1'b1;
          next_state = IDLE;
        end
      end
      START: next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (core_done) begin
          latch_result = 1'b1;
          next_state   = HOLD;
        end
      end
      HOLD: begin
        if (result_ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      key_stage    <= '0;
      msg_stage    <= '0;
      key_out      <= '0;
      msg_out      <= '0;
      key_loaded   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      err <= cmd_err || timeout_hit;
      if (clr_load) begin
        cnt       <= '0;
        key_stage <= '0;
        msg_stage <= '0;
      end else if (accept && state == LOAD_KEY) begin
        cnt       <= cnt + 1'b1;
        key_stage <= key_shift;
      end else if (accept && state == LOAD_MSG) begin
        cnt       <= cnt + 1'b1;
        msg_stage <= msg_shift;
      end
      if (key_commit) begin
        key_out    <= key_shift;
        key_loaded <= 1'b1;
      end
      if (msg_commit) begin
        msg_out <= msg_shift;
      end
      if (latch_result) begin
        result       <= core_result;
        result_valid <= 1'b1;
      end else if (state == HOLD && result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: directed cases from the test plan
// plus randomized key/message/result rounds against a byte-level model.
module tb_aes_block_loader;

`ifdef AES_LOADER_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic [127:0] msg_out;
  logic [127:0] key_out;
  logic         start;
  logic         core_done;
  logic [127:0] core_result;
  logic [127:0] result;
  logic         result_valid;
  logic         result_ack;
  logic         key_loaded;
  logic         busy;
  logic         err;
  logic [2:0]   fsm_state;

  aes_block_loader #(.nk(4), .nb(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .msg_out(msg_out), .key_out(key_out),
    .start(start), .core_done(core_done), .core_result(core_result),
    .result(result), .result_valid(result_valid), .result_ack(result_ack),
    .key_loaded(key_loaded), .busy(busy), .err(err), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int start_count = 0;
  int exp_starts  = 0;

  // model state
  logic [127:0] model_key;
  logic [127:0] model_msg;
  logic [127:0] model_result;
  logic         model_key_loaded;
  logic [127:0] exp_q[$];

  always @(negedge clk) if (start) start_count++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) step();
    byte_in    = b;
    byte_valid = 1'b1;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic model_reset();
    model_key        = '0;
    model_msg        = '0;
    model_result     = '0;
    model_key_loaded = 1'b0;
  endtask

  // Sends data MSB first after cmd; checks committed outputs never move early.
  task automatic send_block(input logic [7:0] cmd, input logic [127:0] data,
                            input int max_gap, input bit is_msg);
    send_byte(cmd, $urandom_range(0, max_gap));
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        if (is_msg) check("msg_no_partial", msg_out, model_msg);
        else        check("key_no_partial", key_out, model_key);
        if (!is_msg) check("key_loaded_before_last", {127'd0, key_loaded}, {127'd0, model_key_loaded});
      end
      send_byte(data[127-8*i -: 8], $urandom_range(0, max_gap));
    end
    if (is_msg) model_msg = data;
    else begin
      model_key        = data;
      model_key_loaded = 1'b1;
    end
  endtask

  task automatic check_key_done(input string tag);
    check({tag, "_key_out"}, key_out, model_key);
    check({tag, "_key_loaded"}, {127'd0, key_loaded}, 128'd1);
    check({tag, "_msg_kept"}, msg_out, model_msg);
    check({tag, "_idle"}, {127'd0, busy}, 128'd0);
  endtask

  // Called right after the last message byte edge.
  task automatic finish_msg(input string tag, input logic [127:0] res,
                            input int latency, input int ack_delay);
    check({tag, "_msg_out"}, msg_out, model_msg);
    check({tag, "_start_hi"}, {127'd0, start}, 128'd1);
    exp_starts++;
    step();
    check({tag, "_start_lo"}, {127'd0, start}, 128'd0);
    check({tag, "_busy"}, {127'd0, busy}, 128'd1);
    check({tag, "_not_ready"}, {127'd0, byte_ready}, 128'd0);
    repeat (latency) step();
    core_result = res;
    core_done   = 1'b1;
    exp_q.push_back(res);
    step();
    core_done    = 1'b0;
    model_result = exp_q.pop_front();
    check({tag, "_result"}, result, model_result);
    check({tag, "_rvalid"}, {127'd0, result_valid}, 128'd1);
    repeat (ack_delay) step();
    check({tag, "_rvalid_held"}, {127'd0, result_valid}, 128'd1);
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    check({tag, "_rvalid_clr"}, {127'd0, result_valid}, 128'd0);
    check({tag, "_ready"}, {127'd0, byte_ready}, 128'd1);
    check({tag, "_result_kept"}, result, model_result);
  endtask

  logic [127:0] data;
  logic [7:0]   bad;

  initial begin
    rst = 1'b1; byte_in = '0; byte_valid = 1'b0; core_done = 1'b0;
    core_result = '0; result_ack = 1'b0;
    model_reset();
    #3;
    check("rst_msg", msg_out, 128'd0);
    check("rst_key", key_out, 128'd0);
    check("rst_result", result, 128'd0);
    check("rst_flags", {123'd0, start, result_valid, key_loaded, err, busy}, 128'd0);
    check("rst_ready", {127'd0, byte_ready}, 128'd1);
    @(negedge clk) rst = 1'b0;
    step();

    // command errors
    send_byte(8'h4D, 0);
    check("m_nokey_err", {127'd0, err}, 128'd1);
    check("m_nokey_idle", {127'd0, busy}, 128'd0);
    step();
    check("err_one_cycle", {127'd0, err}, 128'd0);
    send_byte(8'h55, 0);
    check("bad_cmd_err", {127'd0, err}, 128'd1);

    // directed key and message
    for (int i = 0; i < 16; i++) data[127-8*i -: 8] = 8'(i);
    send_block(8'h4B, data, 0, 1'b0);
    check_key_done("dir");
    check("dir_key_value", key_out, 128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 16; i++) data[127-8*i -: 8] = 8'(i * 17);
    send_block(8'h4D, data, 0, 1'b1);
    check("dir_msg_value", msg_out, 128'h00112233445566778899aabbccddeeff);
    finish_msg("dir", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2, 5);

    // core_done outside WAIT_DONE is ignored
    core_result = 128'hdeadbeef_00000000_11111111_22222222;
    core_done   = 1'b1;
    step();
    core_done = 1'b0;
    check("idle_done_result", result, model_result);
    check("idle_done_rvalid", {127'd0, result_valid}, 128'd0);

    // randomized rounds
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        data = {$urandom, $urandom, $urandom, $urandom};
        send_block(8'h4B, data, 2, 1'b0);
        check_key_done("rnd");
      end
      if ($urandom_range(0, 2) == 0) begin
        bad = 8'($urandom_range(0, 255));
        if (bad == 8'h4B || bad == 8'h4D) bad = 8'hA5;
        send_byte(bad, $urandom_range(0, 2));
        check("rnd_bad_err", {127'd0, err}, 128'd1);
      end
      data = {$urandom, $urandom, $urandom, $urandom};
      send_block(8'h4D, data, 2, 1'b1);
      finish_msg("rnd", {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 4), $urandom_range(0, 3));
    end

    // stalled message load
    data = {$urandom, $urandom, $urandom, $urandom};
    send_byte(8'h4D, 0);
    for (int i = 0; i < 3; i++) send_byte(data[127-8*i -: 8], 0);
`ifdef AES_LOADER_TIMEOUT_EN
    repeat (TMO - 1) step();
    check("tmo_not_yet", {127'd0, err}, 128'd0);
    step();
    check("tmo_err", {127'd0, err}, 128'd1);
    check("tmo_idle", {127'd0, busy}, 128'd0);
    check("tmo_msg_kept", msg_out, model_msg);
    check("tmo_key_loaded", {127'd0, key_loaded}, 128'd1);
`else
    repeat (100) step();
    check("stall_busy", {127'd0, busy}, 128'd1);
    check("stall_ready", {127'd0, byte_ready}, 128'd1);
    check("stall_no_err", {127'd0, err}, 128'd0);
    for (int i = 3; i < 16; i++) send_byte(data[127-8*i -: 8], 0);
    model_msg = data;
    finish_msg("stall", {$urandom, $urandom, $urandom, $urandom}, 1, 1);
`endif

    // reset in the middle of a message load
    data = {$urandom, $urandom, $urandom, $urandom};
    send_byte(8'h4D, 0);
    for (int i = 0; i < 7; i++) send_byte(data[127-8*i -: 8], 0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_msg", msg_out, model_msg);
    check("mid_rst_key", key_out, model_key);
    check("mid_rst_flags", {125'd0, key_loaded, busy, start}, 128'd0);
    @(negedge clk) rst = 1'b0;
    step();
    send_byte(8'h4D, 0);
    check("post_rst_m_err", {127'd0, err}, 128'd1);

    step();
    check("start_count", 128'(start_count), 128'(exp_starts));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
